// File: rtl/bus_arbiter_pkg.sv
// Shared types and bus widths for the 2-to-1 bus arbiter.
package bus_arbiter_pkg;

    localparam int ADDR_W        = 32;
    localparam int DATA_W        = 32;
    localparam int SEL_W         = 4;
    localparam int NMASTER_IDX_W = 1;

    typedef enum logic {
        IDLE,
        BUSY
    } state_e;

    typedef struct packed {
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] wdata;
        logic [SEL_W-1:0]  wsel;
        logic              valid;
    } breq_t;

endpackage

// File: rtl/bus_arbiter_2to1_rr_pick2.sv
// Two-way round-robin picker: on a tie the master not served last wins.
module rr_pick2 (
    input  logic [1:0] req_i,
    input  logic       last_i,
    output logic       any_o,
    output logic       idx_o
);

    assign any_o = |req_i;
    assign idx_o = (&req_i) ? ~last_i : req_i[1];

endmodule

// File: rtl/bus_arbiter_2to1.sv
// Two-master round-robin arbiter in front of the simulation RAM.
// Optional slave timeout enabled by defining BUS_ARBITER_TIMEOUT_EN.
module bus_arbiter_2to1
    import bus_arbiter_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [ADDR_W-1:0] m0_address,
    input  logic [DATA_W-1:0] m0_wdata,
    input  logic [SEL_W-1:0]  m0_wsel,
    input  logic              m0_valid,
    output logic [DATA_W-1:0] m0_rdata,
    output logic              m0_ready,
    output logic              m0_error,
    input  logic [ADDR_W-1:0] m1_address,
    input  logic [DATA_W-1:0] m1_wdata,
    input  logic [SEL_W-1:0]  m1_wsel,
    input  logic              m1_valid,
    output logic [DATA_W-1:0] m1_rdata,
    output logic              m1_ready,
    output logic              m1_error,
    output logic [ADDR_W-1:0] s_address,
    output logic [DATA_W-1:0] s_wdata,
    output logic [SEL_W-1:0]  s_wsel,
    output logic              s_valid,
    input  logic [DATA_W-1:0] s_rdata,
    input  logic              s_ready,
    input  logic              s_error
);

    state_e                   state_q, state_d;
    logic [NMASTER_IDX_W-1:0] gnt_q, gnt_d;
    logic                     last_q, last_d;

    breq_t             req0, req1, sel;
    logic              any, idx, resp, tmo;
    logic [DATA_W-1:0] rsp_rdata;
    logic              rsp_ready, rsp_error;

    assign req0 = {m0_address, m0_wdata, m0_wsel, m0_valid};
    assign req1 = {m1_address, m1_wdata, m1_wsel, m1_valid};
    assign sel  = gnt_q[0] ? req1 : req0;
    assign resp = s_ready | s_error;

    rr_pick2 u_pick (
        .req_i  ({m1_valid, m0_valid}),
        .last_i (last_q),
        .any_o  (any),
        .idx_o  (idx)
    );

`ifdef BUS_ARBITER_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT_CYCLES) + 1;

    logic [CNT_W-1:0] cnt_q, cnt_d;

    assign tmo = (state_q == BUSY) && !resp
              && (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1));

    // Held at zero outside BUSY so every transaction starts from 0.
    always_comb begin
        cnt_d = '0;
        if (state_q == BUSY && !resp && !tmo) begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end
`else
    logic [31:0] unused_tmo;

    assign unused_tmo = 32'(TIMEOUT_CYCLES);
    assign tmo        = 1'b0;
`endif

    always_comb begin
        state_d   = state_q;
        gnt_d     = gnt_q;
        last_d    = last_q;
        s_address = '0;
        s_wdata   = '0;
        s_wsel    = '0;
        s_valid   = 1'b0;
        rsp_rdata = '0;
        rsp_ready = 1'b0;
        rsp_error = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (any) begin
                    gnt_d   = idx;
                    state_d = BUSY;
                end
            end
            BUSY: begin
                s_address = sel.addr;
                s_wdata   = sel.wdata;
                s_wsel    = sel.wsel;
                s_valid   = sel.valid & ~tmo;
                if (!sel.valid) begin
                    // Master withdrew: abort silently, fairness untouched.
                    state_d = IDLE;
                end else begin
                    rsp_rdata = s_rdata;
                    rsp_ready = s_ready;
                    rsp_error = s_error | tmo;
                    if (resp || tmo) begin
                        state_d = IDLE;
                        last_d  = gnt_q[0];
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            gnt_q   <= '0;
            last_q  <= 1'b1;
        end else begin
            state_q <= state_d;
            gnt_q   <= gnt_d;
            last_q  <= last_d;
        end
    end

    assign m0_rdata = gnt_q[0] ? '0 : rsp_rdata;
    assign m0_ready = ~gnt_q[0] & rsp_ready;
    assign m0_error = ~gnt_q[0] & rsp_error;
    assign m1_rdata = gnt_q[0] ? rsp_rdata : '0;
    assign m1_ready = gnt_q[0] & rsp_ready;
    assign m1_error = gnt_q[0] & rsp_error;

endmodule

// File: tb/tb_bus_arbiter_2to1.sv
// Directed bench for bus_arbiter_2to1 with a small behavioural RAM.
// The timeout steps run only when BUS_ARBITER_TIMEOUT_EN is defined.
module tb_bus_arbiter_2to1;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] m0_address, m0_wdata, m0_rdata;
    logic [3:0]  m0_wsel;
    logic        m0_valid, m0_ready, m0_error;
    logic [31:0] m1_address, m1_wdata, m1_rdata;
    logic [3:0]  m1_wsel;
    logic        m1_valid, m1_ready, m1_error;
    logic [31:0] s_address, s_wdata, s_rdata;
    logic [3:0]  s_wsel;
    logic        s_valid, s_ready, s_error;

    int total = 0;
    int bad   = 0;

    logic        stall;
    logic [31:0] mem [0:1023];

    localparam logic [31:0] ERR_ADDR = 32'hF000_0000;

    always #5 clk = ~clk;

    bus_arbiter_2to1 #(.TIMEOUT_CYCLES(4)) dut (
        .clk        (clk),
        .rst        (rst),
        .m0_address (m0_address),
        .m0_wdata   (m0_wdata),
        .m0_wsel    (m0_wsel),
        .m0_valid   (m0_valid),
        .m0_rdata   (m0_rdata),
        .m0_ready   (m0_ready),
        .m0_error   (m0_error),
        .m1_address (m1_address),
        .m1_wdata   (m1_wdata),
        .m1_wsel    (m1_wsel),
        .m1_valid   (m1_valid),
        .m1_rdata   (m1_rdata),
        .m1_ready   (m1_ready),
        .m1_error   (m1_error),
        .s_address  (s_address),
        .s_wdata    (s_wdata),
        .s_wsel     (s_wsel),
        .s_valid    (s_valid),
        .s_rdata    (s_rdata),
        .s_ready    (s_ready),
        .s_error    (s_error)
    );

    // RAM answers in the same cycle; response decoded from address only.
    assign s_rdata = mem[s_address[11:2]];
    assign s_ready = !stall && (s_address != ERR_ADDR);
    assign s_error = !stall && (s_address == ERR_ADDR);

    always @(posedge clk) begin
        if (s_valid && s_ready) begin
            for (int b = 0; b < 4; b++) begin
                if (s_wsel[b]) begin
                    mem[s_address[11:2]][8*b +: 8] <= s_wdata[8*b +: 8];
                end
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag,
                       input logic [31:0] obs,
                       input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    initial begin
        for (int i = 0; i < 1024; i++) mem[i] = 32'(i);
        mem[32'h100 >> 2] = 32'hDEAD_BEEF;
        mem[32'h104 >> 2] = 32'h1111_2222;
        mem[32'h200 >> 2] = 32'hAAAA_BBBB;
        stall      = 1'b0;
        rst        = 1'b1;
        m0_address = '0;
        m0_wdata   = '0;
        m0_wsel    = '0;
        m0_valid   = 1'b0;
        m1_address = '0;
        m1_wdata   = '0;
        m1_wsel    = '0;
        m1_valid   = 1'b0;
        step();
        step();
        chk("rst_s_valid", 32'(s_valid), 0);
        chk("rst_m0_ready", 32'(m0_ready), 0);
        chk("rst_m1_ready", 32'(m1_ready), 0);
        rst = 1'b0;

        // m0 read 0x100: cycle 1 IDLE, cycle 2 BUSY with response.
        m0_address = 32'h100;
        m0_valid   = 1'b1;
        #1;
        chk("rd_c1_s_valid", 32'(s_valid), 0);
        chk("rd_c1_m0_ready", 32'(m0_ready), 0);
        step();
        chk("rd_c2_s_valid", 32'(s_valid), 1);
        chk("rd_c2_s_addr", s_address, 32'h100);
        chk("rd_c2_m0_ready", 32'(m0_ready), 1);
        chk("rd_c2_m0_rdata", m0_rdata, 32'hDEAD_BEEF);
        chk("rd_c2_m1_ready", 32'(m1_ready), 0);
        chk("rd_c2_m1_rdata", m1_rdata, 0);
        step();
        m0_valid = 1'b0;

        // Both request continuously; m0 was served last, so m1 leads.
        m0_address = 32'h100;
        m1_address = 32'h104;
        m0_valid   = 1'b1;
        m1_valid   = 1'b1;
        for (int k = 1; k <= 8; k++) begin
            step();
            if (k % 2 == 0) begin
                chk("alt_idle_m0_ready", 32'(m0_ready), 0);
                chk("alt_idle_m1_ready", 32'(m1_ready), 0);
            end else if ((k / 2) % 2 == 0) begin
                chk("alt_m1_ready", 32'(m1_ready), 1);
                chk("alt_m1_block_m0", 32'(m0_ready), 0);
                chk("alt_m1_rdata", m1_rdata, 32'h1111_2222);
            end else begin
                chk("alt_m0_ready", 32'(m0_ready), 1);
                chk("alt_m0_block_m1", 32'(m1_ready), 0);
                chk("alt_m0_rdata", m0_rdata, 32'hDEAD_BEEF);
            end
        end
        m0_valid = 1'b0;
        m1_valid = 1'b0;

        // m1 partial write, then m0 reads it back.
        m1_address = 32'h200;
        m1_wdata   = 32'h1234_5678;
        m1_wsel    = 4'b0011;
        m1_valid   = 1'b1;
        step();
        chk("wr_s_wsel", 32'(s_wsel), 32'h3);
        chk("wr_s_wdata", s_wdata, 32'h1234_5678);
        chk("wr_s_addr", s_address, 32'h200);
        chk("wr_m1_ready", 32'(m1_ready), 1);
        chk("wr_m0_ready", 32'(m0_ready), 0);
        step();
        m1_valid   = 1'b0;
        m1_wsel    = '0;
        m0_address = 32'h200;
        m0_valid   = 1'b1;
        step();
        chk("rb_m0_ready", 32'(m0_ready), 1);
        chk("rb_low_half", 32'(m0_rdata[15:0]), 32'h5678);
        chk("rb_full", m0_rdata, 32'hAAAA_5678);
        step();
        m0_valid = 1'b0;

        // Slave error on 0xF000_0000.
        m0_address = ERR_ADDR;
        m0_valid   = 1'b1;
        step();
        chk("err_m0_error", 32'(m0_error), 1);
        chk("err_m0_ready", 32'(m0_ready), 0);
        chk("err_m1_error", 32'(m1_error), 0);
        step();
        chk("err_idle_s_valid", 32'(s_valid), 0);
        chk("err_idle_m0_error", 32'(m0_error), 0);
        m0_valid = 1'b0;

        // Reset in the middle of a stalled m1 transaction.
        stall      = 1'b1;
        m1_address = 32'h104;
        m1_valid   = 1'b1;
        step();
        chk("rb_busy_s_valid", 32'(s_valid), 1);
        chk("rb_busy_m1_ready", 32'(m1_ready), 0);
        rst = 1'b1;
        step();
        chk("rst_mid_s_valid", 32'(s_valid), 0);
        chk("rst_mid_m1_ready", 32'(m1_ready), 0);
        chk("rst_mid_m1_error", 32'(m1_error), 0);
        rst        = 1'b0;
        stall      = 1'b0;
        m0_address = 32'h100;
        m0_valid   = 1'b1;
        step();
        chk("rst_tie_m0_ready", 32'(m0_ready), 1);
        chk("rst_tie_m1_ready", 32'(m1_ready), 0);
        chk("rst_tie_s_addr", s_address, 32'h100);
        step();
        m0_valid = 1'b0;
        m1_valid = 1'b0;

`ifdef BUS_ARBITER_TIMEOUT_EN
        // Slave never answers: error lands on the 4th BUSY cycle.
        stall      = 1'b1;
        m0_address = 32'h100;
        m0_valid   = 1'b1;
        step();
        chk("tmo_b1_s_valid", 32'(s_valid), 1);
        chk("tmo_b1_m0_error", 32'(m0_error), 0);
        step();
        step();
        chk("tmo_b3_m0_error", 32'(m0_error), 0);
        step();
        chk("tmo_b4_m0_error", 32'(m0_error), 1);
        chk("tmo_b4_m0_ready", 32'(m0_ready), 0);
        chk("tmo_b4_s_valid", 32'(s_valid), 0);
        step();
        chk("tmo_idle_s_valid", 32'(s_valid), 0);
        chk("tmo_idle_m0_error", 32'(m0_error), 0);
        m0_valid = 1'b0;
        stall    = 1'b0;
`endif

        step();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
